// File: rtl/gb_ppu_pkg.sv
// Shared constants, sprite-queue entry layout and scan state type for the PPU OAM search stage.
package gb_ppu_pkg;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_ENTRIES = 40;
  localparam int          MAX_SPRITES = 10;
  localparam int          OAM_BYTES   = 4 * OAM_ENTRIES;

  localparam int FLD_W    = 8;
  localparam int ENT_W    = 48;
  localparam int OFS_Y    = 40;
  localparam int OFS_X    = 32;
  localparam int OFS_TILE = 24;
  localparam int OFS_ATTR = 16;
  localparam int OFS_IDX  = 8;
  localparam int OFS_VLD  = 0;

  // OAM Y is stored with a +16 bias relative to the screen line
  localparam logic [8:0] LINE_OFS = 9'd16;
  localparam logic [8:0] H_SHORT  = 9'd8;
  localparam logic [8:0] H_TALL   = 9'd16;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_e;

  function automatic logic [ENT_W-1:0] pack_entry(input logic [7:0] y, input logic [7:0] x,
                                                  input logic [7:0] tile, input logic [7:0] attr,
                                                  input logic [7:0] idx);
    logic [ENT_W-1:0] e;
    e = '0;
    e[OFS_Y    +: FLD_W] = y;
    e[OFS_X    +: FLD_W] = x;
    e[OFS_TILE +: FLD_W] = tile;
    e[OFS_ATTR +: FLD_W] = attr;
    e[OFS_IDX  +: FLD_W] = idx;
    e[OFS_VLD  +: FLD_W] = 8'h01;
    return e;
  endfunction
endpackage

// File: rtl/oam_line_compare.sv
// Combinational test of whether a sprite's vertical extent covers the current line.
module oam_line_compare
  import gb_ppu_pkg::*;
(
  input  logic [7:0] y_i,
  input  logic [7:0] ly_i,
  input  logic       obj_size_i,
  output logic       hit_o
);
  logic [8:0] line9;
  logic [8:0] top9;
  logic [8:0] bot9;

  // 9-bit math so Y near 255 plus height cannot wrap
  assign line9 = {1'b0, ly_i} + LINE_OFS;
  assign top9  = {1'b0, y_i};
  assign bot9  = top9 + (obj_size_i ? H_TALL : H_SHORT);
  assign hit_o = (line9 >= top9) && (line9 < bot9);
endmodule

// File: rtl/oam_scan_fsm.sv
// Mode-2 OAM search: streams all OAM entries and builds the per-line sprite queue for mode 3.
//
// state  | meaning
// S_IDLE | waiting for start, oam_a parked at OAM_BASE
// S_SCAN | issuing one OAM byte address per cycle, evaluating each entry on its attr byte
// S_DONE | one-cycle done pulse, queue valid
module oam_scan_fsm
  import gb_ppu_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              done_out,
  output logic                              busy,
  input  logic [7:0]                        oam_dout,
  output logic [15:0]                       oam_a,
  output logic [7:0]                        oam_din,
  output logic                              oam_wr,
  input  logic [7:0]                        LCDC,
  input  logic [7:0]                        LY,
  output logic [MAX_SPRITES-1:0][ENT_W-1:0] sprite_queue,
  output logic [3:0]                        sprite_count
);
  localparam logic [15:0] OAM_LAST = OAM_BASE + 16'(OAM_BYTES - 1);

  scan_state_e                      state_q;
  logic [7:0]                       cnt_q;
  logic [7:0]                       ly_q;
  logic                             size_q;
  logic [7:0]                       y_q;
  logic [7:0]                       x_q;
  logic [7:0]                       tile_q;
  logic [MAX_SPRITES-1:0][ENT_W-1:0] queue_q;
  logic [3:0]                       count_q;
  logic [15:0]                      oam_a_q;
  logic                             done_q;
  logic                             busy_q;

  logic [7:0] byte_idx;
  logic [5:0] ent_idx;
  logic       hit;
  logic       unused_lcdc;

  // cnt_q is one ahead of the byte on oam_dout because of the read latency
  assign byte_idx    = cnt_q - 8'd1;
  assign ent_idx     = byte_idx[7:2];
  assign unused_lcdc = ^{LCDC[7:3], LCDC[0]};

  oam_line_compare u_cmp (
    .y_i        (y_q),
    .ly_i       (ly_q),
    .obj_size_i (size_q),
    .hit_o      (hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ly_q    <= '0;
      size_q  <= 1'b0;
      y_q     <= '0;
      x_q     <= '0;
      tile_q  <= '0;
      queue_q <= '0;
      count_q <= '0;
      oam_a_q <= OAM_BASE;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        ly_q    <= LY;
        size_q  <= LCDC[2];
        queue_q <= '0;
        count_q <= '0;
        cnt_q   <= '0;
        oam_a_q <= OAM_BASE;
        if (!LCDC[1]) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end else begin
          state_q <= S_SCAN;
          busy_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SCAN: begin
            cnt_q <= cnt_q + 8'd1;
            if (oam_a_q != OAM_LAST) oam_a_q <= oam_a_q + 16'd1;
            if (cnt_q != 8'd0) begin
              case (byte_idx[1:0])
                2'd0: y_q    <= oam_dout;
                2'd1: x_q    <= oam_dout;
                2'd2: tile_q <= oam_dout;
                2'd3: begin
                  if (hit) begin
                    queue_q[count_q] <= pack_entry(y_q, x_q, tile_q, oam_dout, {2'b00, ent_idx});
                    count_q          <= count_q + 4'd1;
                  end
                  if ((hit && (count_q == 4'(MAX_SPRITES - 1))) ||
                      (ent_idx == 6'(OAM_ENTRIES - 1))) begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    oam_a_q <= OAM_BASE;
                  end
                end
                default: ;
              endcase
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign done_out     = done_q;
  assign busy         = busy_q;
  assign oam_a        = oam_a_q;
  assign oam_din      = 8'h00;
  assign oam_wr       = 1'b0;
  assign sprite_queue = queue_q;
  assign sprite_count = count_q;
endmodule

// File: tb/tb_oam_scan_fsm.sv
// Directed self-checking bench for the OAM search stage with a synchronous-read OAM model.
module tb_oam_scan_fsm;
  logic             clk;
  logic             rst;
  logic             start;
  logic             done_out;
  logic             busy;
  logic [7:0]       oam_dout;
  logic [15:0]      oam_a;
  logic [7:0]       oam_din;
  logic             oam_wr;
  logic [7:0]       LCDC;
  logic [7:0]       LY;
  logic [9:0][47:0] sprite_queue;
  logic [3:0]       sprite_count;

  logic [7:0] mem [160];
  int total;
  int bad;

  oam_scan_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .done_out     (done_out),
    .busy         (busy),
    .oam_dout     (oam_dout),
    .oam_a        (oam_a),
    .oam_din      (oam_din),
    .oam_wr       (oam_wr),
    .LCDC         (LCDC),
    .LY           (LY),
    .sprite_queue (sprite_queue),
    .sprite_count (sprite_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (oam_a >= 16'hFE00 && oam_a < 16'hFEA0) oam_dout <= mem[int'(oam_a - 16'hFE00)];
    else oam_dout <= 8'hFF;
  end

  typedef struct {
    logic [7:0]  ly;
    logic [7:0]  lcdc;
    logic [7:0]  y;
    logic [7:0]  x;
    logic [7:0]  tile;
    logic [7:0]  attr;
    int          idx;
    int          exp_cnt;
    int          exp_done;
    logic [47:0] exp_q0;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 160; i++) mem[i] = 8'h00;
  endtask

  task automatic put_entry(input int i, input logic [7:0] y, input logic [7:0] x,
                           input logic [7:0] t, input logic [7:0] a);
    mem[4*i] = y; mem[4*i+1] = x; mem[4*i+2] = t; mem[4*i+3] = a;
  endtask

  task automatic pulse_start(input logic [7:0] ly, input logic [7:0] lcdc);
    @(negedge clk);
    LY = ly; LCDC = lcdc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // n counts cycles after the start edge; n=1 is cycle T+1
  task automatic watch(input int budget, input bit sweep, output int done_n,
                       output bit seq_ok, output bit busy_ok, output logic [15:0] max_a);
    done_n = -1; seq_ok = 1'b1; busy_ok = 1'b1; max_a = 16'h0000;
    for (int n = 1; n <= budget && done_n < 0; n++) begin
      @(negedge clk);
      if (oam_a > max_a) max_a = oam_a;
      if (sweep && n <= 160 && oam_a !== 16'hFE00 + 16'(n - 1)) seq_ok = 1'b0;
      if (done_out === 1'b1) done_n = n;
      else if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int          dn;
    bit          sok;
    bit          bok;
    logic [15:0] ma;
    logic [47:0] orq;
    bit          ok;

    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; LY = 8'h00; LCDC = 8'h00;
    clear_mem();

    vecs[0] = '{8'h00, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00,  0, 0, 162, 48'h0};
    vecs[1] = '{8'h00, 8'h82, 8'h10, 8'h08, 8'h12, 8'h20,  5, 1, 162, 48'h10_08_12_20_05_01};
    vecs[2] = '{8'h07, 8'h82, 8'h10, 8'h33, 8'h44, 8'h55,  0, 1, 162, 48'h10_33_44_55_00_01};
    vecs[3] = '{8'h08, 8'h82, 8'h10, 8'h33, 8'h44, 8'h55,  0, 0, 162, 48'h0};
    vecs[4] = '{8'h0F, 8'h86, 8'h10, 8'h01, 8'h02, 8'h03,  2, 1, 162, 48'h10_01_02_03_02_01};
    vecs[5] = '{8'h10, 8'h86, 8'h10, 8'h01, 8'h02, 8'h03,  2, 0, 162, 48'h0};
    vecs[6] = '{8'h00, 8'h82, 8'h08, 8'h09, 8'h0A, 8'h0B,  3, 0, 162, 48'h0};
    vecs[7] = '{8'h00, 8'h80, 8'h10, 8'h08, 8'h12, 8'h20,  5, 0,   1, 48'h0};
    vecs[8] = '{8'h04, 8'h82, 8'h14, 8'h00, 8'h7E, 8'h81, 39, 1, 162, 48'h14_00_7E_81_27_01};
    vecs[9] = '{8'h00, 8'h82, 8'h10, 8'hC8, 8'h01, 8'hFF, 17, 1, 162, 48'h10_C8_01_FF_11_01};

    #22;
    chk("reset_busy",  busy, 0);
    chk("reset_done",  done_out, 0);
    chk("reset_oam_a", oam_a, 16'hFE00);
    chk("reset_count", sprite_count, 0);
    chk("reset_queue", (sprite_queue == '0), 1);
    chk("reset_wr",    {oam_wr, oam_din}, 0);
    @(negedge clk); rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      clear_mem();
      put_entry(vecs[v].idx, vecs[v].y, vecs[v].x, vecs[v].tile, vecs[v].attr);
      pulse_start(vecs[v].ly, vecs[v].lcdc);
      watch(300, vecs[v].lcdc[1], dn, sok, bok, ma);
      chk($sformatf("v%0d_done_cycle", v), 64'(dn), 64'(vecs[v].exp_done));
      chk($sformatf("v%0d_count", v), sprite_count, 64'(vecs[v].exp_cnt));
      chk($sformatf("v%0d_q0", v), sprite_queue[0], vecs[v].exp_q0);
      orq = '0;
      for (int i = 1; i < 10; i++) orq = orq | sprite_queue[i];
      chk($sformatf("v%0d_rest_zero", v), orq, 0);
      if (vecs[v].lcdc[1]) begin
        chk($sformatf("v%0d_addr_sweep", v), sok, 1);
        chk($sformatf("v%0d_busy_scan", v), bok, 1);
      end else begin
        chk($sformatf("v%0d_addr_parked", v), ma, 16'hFE00);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_one_cycle", v), done_out, 0);
      chk($sformatf("v%0d_idle_busy", v), busy, 0);
      chk($sformatf("v%0d_idle_addr", v), oam_a, 16'hFE00);
      chk($sformatf("v%0d_count_hold", v), sprite_count, 64'(vecs[v].exp_cnt));
    end

    // ten-sprite limit ends the scan early
    clear_mem();
    for (int i = 0; i < 12; i++) put_entry(i, 8'h10, 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i));
    pulse_start(8'h03, 8'h82);
    watch(300, 1'b0, dn, sok, bok, ma);
    chk("limit_done_cycle", 64'(dn), 42);
    chk("limit_count", sprite_count, 10);
    chk("limit_max_addr_below_FE30", (ma < 16'hFE30), 1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("limit_q%0d", i), sprite_queue[i],
          {8'h10, 8'(8'h30 + i), 8'(8'h40 + i), 8'(8'h50 + i), 8'(i), 8'h01});
    @(negedge clk);
    chk("limit_done_one_cycle", done_out, 0);
    chk("limit_idle_addr", oam_a, 16'hFE00);

    // async reset mid-scan
    clear_mem();
    for (int i = 0; i < 4; i++) put_entry(i, 8'h10, 8'h01, 8'h02, 8'h03);
    pulse_start(8'h00, 8'h82);
    for (int n = 1; n <= 50; n++) @(negedge clk);
    chk("rst_pre_count", sprite_count, 4);
    rst = 1'b1;
    #1;
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done_out, 0);
    chk("rst_oam_a", oam_a, 16'hFE00);
    chk("rst_count", sprite_count, 0);
    chk("rst_queue", (sprite_queue == '0), 1);
    @(negedge clk); rst = 1'b0;
    ok = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done_out !== 1'b0 || oam_a !== 16'hFE00) ok = 1'b0;
    end
    chk("rst_stays_idle", ok, 1);

    // restart mid-scan with a new line; later LY/LCDC changes must be ignored
    clear_mem();
    for (int i = 0; i < 4; i++) put_entry(i, 8'h10, 8'h01, 8'h02, 8'h03);
    put_entry(20, 8'h28, 8'h66, 8'h77, 8'h88);
    pulse_start(8'h00, 8'h82);
    for (int n = 1; n <= 49; n++) @(negedge clk);
    chk("restart_pre_count", sprite_count, 4);
    pulse_start(8'd26, 8'h82);
    chk("restart_cleared", sprite_count, 0);
    LY = 8'h00; LCDC = 8'h00;
    watch(300, 1'b1, dn, sok, bok, ma);
    chk("restart_done_cycle", 64'(dn), 162);
    chk("restart_sweep", sok, 1);
    chk("restart_count", sprite_count, 1);
    chk("restart_q0", sprite_queue[0], 48'h28_66_77_88_14_01);
    chk("restart_q1", sprite_queue[1], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
